// File: rtl/fixed_point_pkg.sv
// Shared constants for the fixed-point ALU and the stack machine that drives it:
// opcodes, ALU state encoding and the default-width range limits.
package fixed_point_pkg;

    localparam logic [2:0] OP_ADD      = 3'd0;
    localparam logic [2:0] OP_SUB      = 3'd1;
    localparam logic [2:0] OP_MUL      = 3'd2;
    localparam logic [2:0] OP_DIV      = 3'd3;
    localparam logic [2:0] OP_MIN      = 3'd4;
    localparam logic [2:0] OP_MAX      = 3'd5;
    // Stack-machine-only opcode; the ALU treats 6/7 as reserved.
    localparam logic [2:0] OP_PUSH_VAR = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DONE     = 2'd3
    } alu_state_e;

    localparam int          FP_DEFAULT_WIDTH = 16;
    localparam logic [15:0] FP_MAX_VALUE     = 16'h7FFF;
    localparam logic [15:0] FP_MIN_VALUE     = 16'h8000;

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential restoring divider on unsigned magnitudes: one quotient bit per cycle,
// quotient = (dividend_mag << FW) / divisor_mag, truncated.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int NW = 16,
    parameter int FW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NW-1:0]    dividend_mag,
    input  logic [NW-1:0]    divisor_mag,
    output logic [NW+FW-1:0] quotient,
    output logic             done
);

    localparam int QW = NW + FW;
    localparam int CW = $clog2(QW + 1);

    logic [QW-1:0] quo_q, quo_d;
    logic [NW-1:0] rem_q, rem_d;
    logic [NW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [NW:0]   rem_shift;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, quo_q[QW-1]};
        if (start && !busy_q) begin
            quo_d  = {dividend_mag, {FW{1'b0}}};
            rem_d  = '0;
            dvs_d  = divisor_mag;
            cnt_d  = CW'(QW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Remainder stays below the divisor, so it always fits in NW bits.
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = NW'(rem_shift - {1'b0, dvs_q});
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[NW-1:0];
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/fixed_point_alu.sv
// Multi-cycle signed Q(I).(F) ALU for the stack machine (result = b OP a).
// Define FIXED_POINT_ALU_SATURATE_EN to clamp ADD/SUB/MUL/DIV overflow instead of wrapping.
module fixed_point_alu
    import fixed_point_pkg::*;
#(
    parameter int  INTEGER_PART_WIDTH    = 8,
    parameter int  FRACTIONAL_PART_WIDTH = 8,
    localparam int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [NUMBER_WIDTH-1:0] a,
    input  logic [NUMBER_WIDTH-1:0] b,
    output logic [NUMBER_WIDTH-1:0] result,
    output logic                    done
);

    localparam int NW = NUMBER_WIDTH;
    localparam int FW = FRACTIONAL_PART_WIDTH;
    localparam int QW = NW + FW;
    localparam int WW = 2 * NW + 2;

    localparam logic [NW-1:0]        MAX_VAL = {1'b0, {(NW-1){1'b1}}};
    localparam logic [NW-1:0]        MIN_VAL = {1'b1, {(NW-1){1'b0}}};
    localparam logic signed [WW-1:0] MAX_W   = {{(WW-NW+1){1'b0}}, {(NW-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_W   = {{(WW-NW+1){1'b1}}, {(NW-1){1'b0}}};

    alu_state_e    state_q, state_d;
    logic [NW-1:0] a_q, a_d;
    logic [NW-1:0] b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic [NW-1:0] result_q, result_d;
    logic          done_q, done_d;

    logic          div_start;
    logic          div_done;
    logic [QW-1:0] div_quot;
    logic [NW:0]   mag_a, mag_b;
    logic          unused_mag_msb;

    logic signed [2*NW-1:0] prod;
    logic [2*NW:0]          mul_mag;
    logic [2*NW:0]          mul_shr;
    logic signed [WW-1:0]   exact_val;
    logic [NW-1:0]          fitted;
    logic [NW-1:0]          exec_result;

    // Magnitudes taken one bit wider so |most negative| is representable.
    assign mag_a          = a[NW-1] ? -{a[NW-1], a} : {a[NW-1], a};
    assign mag_b          = b[NW-1] ? -{b[NW-1], b} : {b[NW-1], b};
    assign unused_mag_msb = mag_a[NW] ^ mag_b[NW];

    assign div_start = (state_q == ST_IDLE) && start && (op == OP_DIV) && (a != '0);

    fixed_point_divider #(
        .NW (NW),
        .FW (FW)
    ) u_divider (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (div_start),
        .dividend_mag (mag_b[NW-1:0]),
        .divisor_mag  (mag_a[NW-1:0]),
        .quotient     (div_quot),
        .done         (div_done)
    );

    assign prod    = $signed(b_q) * $signed(a_q);
    assign mul_mag = prod[2*NW-1] ? -{prod[2*NW-1], prod} : {prod[2*NW-1], prod};
    assign mul_shr = mul_mag >> FW;

    always_comb begin
        exact_val = '0;
        if (state_q == ST_DIV_ITER) begin
            exact_val = (a_q[NW-1] ^ b_q[NW-1]) ? -{{(WW-QW){1'b0}}, div_quot}
                                                :  {{(WW-QW){1'b0}}, div_quot};
        end else begin
            case (op_q)
                OP_ADD:  exact_val = {{(WW-NW){b_q[NW-1]}}, b_q} + {{(WW-NW){a_q[NW-1]}}, a_q};
                OP_SUB:  exact_val = {{(WW-NW){b_q[NW-1]}}, b_q} - {{(WW-NW){a_q[NW-1]}}, a_q};
                OP_MUL:  exact_val = prod[2*NW-1] ? -{1'b0, mul_shr} : {1'b0, mul_shr};
                default: exact_val = '0;
            endcase
        end
    end

`ifdef FIXED_POINT_ALU_SATURATE_EN
    always_comb begin
        if (exact_val > MAX_W)
            fitted = MAX_VAL;
        else if (exact_val < MIN_W)
            fitted = MIN_VAL;
        else
            fitted = exact_val[NW-1:0];
    end
`else
    logic unused_exact_hi;
    assign fitted          = exact_val[NW-1:0];
    assign unused_exact_hi = ^{exact_val[WW-1:NW], MAX_W, MIN_W};
`endif

    always_comb begin
        exec_result = '0;
        case (op_q)
            OP_ADD, OP_SUB, OP_MUL: exec_result = fitted;
            // Only a zero divisor reaches EXEC with a DIV opcode.
            OP_DIV:  exec_result = b_q[NW-1] ? MIN_VAL : MAX_VAL;
            OP_MIN:  exec_result = ($signed(b_q) < $signed(a_q)) ? b_q : a_q;
            OP_MAX:  exec_result = ($signed(b_q) > $signed(a_q)) ? b_q : a_q;
            default: exec_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = div_start ? ST_DIV_ITER : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = exec_result;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DIV_ITER: begin
                if (div_done) begin
                    result_d = fitted;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fixed_point_alu.sv
// Scoreboard bench for fixed_point_alu: expected result/latency queued at start,
// popped and compared when done is seen.
module tb_fixed_point_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic [15:0] result;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fixed_point_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] bv, input logic [15:0] av);
        longint sb = $signed(bv);
        longint sa = $signed(av);
        longint v;
        case (o)
            3'd0: v = sb + sa;
            3'd1: v = sb - sa;
            3'd2: v = (sb * sa) / 256;
            3'd3: begin
                if (sa == 0) return (sb >= 0) ? 16'h7FFF : 16'h8000;
                v = (sb * 256) / sa;
            end
            3'd4: return (sb < sa) ? bv : av;
            3'd5: return (sb > sa) ? bv : av;
            default: return 16'h0000;
        endcase
`ifdef FIXED_POINT_ALU_SATURATE_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] bv,
                          input logic [15:0] av, input bit poke_start);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        op = o; b = bv; a = av; start = 1'b1;
        e.res = model(o, bv, av);
        e.lat = (o == 3'd3 && av != 16'h0) ? 26 : 2;
        sb_q.push_back(e);
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                op = 3'($urandom);
            end
            if (poke_start && lat == 5) start = 1'b1;
            if (poke_start && lat == 6) start = 1'b0;
            if (done) seen = 1'b1;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_val({tag, "_res"}, {16'h0, result}, {16'h0, e.res});
        check_val({tag, "_lat"}, lat, e.lat);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'h0, done}, 32'd0);
        check_val({tag, "_hold"}, {16'h0, result}, {16'h0, e.res});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   any_done;

        repeat (2) @(negedge clk);
        check_val("reset_result", {16'h0, result}, 32'h0);
        check_val("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;

        run_op("add",       3'd0, 16'h0280, 16'h0140, 1'b0);
        run_op("sub",       3'd1, 16'h0280, 16'h0140, 1'b0);
        run_op("sub_swap",  3'd1, 16'h0140, 16'h0280, 1'b0);
        run_op("mul",       3'd2, 16'h0280, 16'h0140, 1'b0);
        run_op("mul_neg",   3'd2, 16'hFF80, 16'h0300, 1'b0);
        run_op("div",       3'd3, 16'h0280, 16'h0140, 1'b0);
        run_op("div_third", 3'd3, 16'h0100, 16'h0300, 1'b0);
        run_op("add_ovf",   3'd0, 16'h7F00, 16'h7F00, 1'b0);
        run_op("sub_ovf",   3'd1, 16'h8000, 16'h0100, 1'b0);
        run_op("mul_ovf",   3'd2, 16'h4000, 16'h0400, 1'b0);
        run_op("div_ovf",   3'd3, 16'h7F00, 16'h0080, 1'b0);
        run_op("div_mneg",  3'd3, 16'h8000, 16'hFFFF, 1'b0);
        run_op("div0_neg",  3'd3, 16'hFF00, 16'h0000, 1'b0);
        run_op("div0_pos",  3'd3, 16'h0100, 16'h0000, 1'b0);
        run_op("min",       3'd4, 16'hFF00, 16'h0100, 1'b0);
        run_op("max",       3'd5, 16'hFF00, 16'h0100, 1'b0);
        run_op("rsvd6",     3'd6, 16'h1234, 16'h0042, 1'b0);
        run_op("rsvd7",     3'd7, 16'h1234, 16'h0042, 1'b0);
        run_op("div_poke",  3'd3, 16'hFB00, 16'h0180, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)),
                   16'($urandom), 16'($urandom), 1'b0);
        end

        // Reset in the middle of a division: abort with no done pulse.
        @(negedge clk);
        op = 3'd3; b = 16'h0280; a = 16'h0140; start = 1'b1;
        e.res = model(3'd3, 16'h0280, 16'h0140);
        e.lat = 26;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_result", {16'h0, result}, 32'h0);
        check_val("rst_mid_done", {31'h0, done}, 32'h0);
        void'(sb_q.pop_front());
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check_val("rst_no_done", {31'h0, any_done}, 32'h0);
        check_val("rst_result_zero", {16'h0, result}, 32'h0);

        run_op("add_after_rst", 3'd0, 16'h0280, 16'h0140, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_alu.md
Name: fixed_point_alu

Overview:
Multi-cycle signed fixed-point arithmetic unit that serves the expression-evaluating stack machine. It takes two stack operands, a (top of stack) and b (second from top), plus a 3-bit opcode. It returns one result through a start/done pulse handshake. Operands and result are two's-complement Q(INTEGER_PART_WIDTH).(FRACTIONAL_PART_WIDTH).

Parameters:
INTEGER_PART_WIDTH, 8, integer bits including sign.
FRACTIONAL_PART_WIDTH, 8, fraction bits.
NUMBER_WIDTH, INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH, operand/result width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MIN, 5 MAX, 6/7 reserved.
a  in  NUMBER_WIDTH  right operand (top of stack).
b  in  NUMBER_WIDTH  left operand (second of stack).
result  out  NUMBER_WIDTH  registered result.
done  out  1  one-cycle pulse: result valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, done=0, result=0, all internal regs cleared. Reset mid-operation aborts; no done pulse follows.
- Operand order (RPN): ADD b+a; SUB b-a; MUL b*a; DIV b/a; MIN min(b,a); MAX max(b,a) (signed compares).
- Handshake: in IDLE, start=1 at an edge latches a, b, op. a/b/op may change afterwards. start while busy is ignored. done is high for exactly one cycle, coincident with the new result. result holds until the next done.
- States: IDLE -> EXEC (ADD/SUB/MIN/MAX/MUL/reserved/div-by-zero) -> DONE -> IDLE; IDLE -> DIV_ITER (NUMBER_WIDTH+FRACTIONAL_PART_WIDTH iterations) -> DONE -> IDLE.
- Latency (start edge to edge where done is first seen high): 2 cycles for single-step ops; NUMBER_WIDTH+FRACTIONAL_PART_WIDTH+2 cycles (26 default) for DIV. done is never asserted in the same cycle as start, so a one-cycle start pulse followed by polling done is valid.
- ADD/SUB: computed at NUMBER_WIDTH+1 bits, then overflow handling (see Optional Feature).
- MUL: full 2*NUMBER_WIDTH signed product. Magnitude shifted right by FRACTIONAL_PART_WIDTH (truncation toward zero), sign reapplied, then overflow handling.
- DIV: restoring divider, one quotient bit per cycle, on magnitudes. Dividend = |b| << FRACTIONAL_PART_WIDTH, divisor = |a|. Quotient is truncated toward zero, sign = sign(b) XOR sign(a), then overflow handling.
- DIV with a=0: no iteration. Result = most positive value (0x7FFF) if b>=0, else most negative (0x8000), regardless of the macro.
- Reserved op 6/7: result 0, single-step latency, done still pulses.
- Most-negative edge cases (e.g. |0x8000|): use NUMBER_WIDTH+1-bit magnitudes so no internal overflow occurs.

Optional Feature:
Macro FIXED_POINT_ALU_SATURATE_EN.
- Defined: ADD/SUB/MUL/DIV results exceeding range clamp to 0x7FFF / 0x8000 (default widths).
- Undefined: results wrap; the low NUMBER_WIDTH bits of the exact (truncated) value are returned.
- Division-by-zero behaviour is identical in both builds.

Decomposition:
- Package fixed_point_pkg holds the opcode constants (OP_ADD..OP_MAX), state encoding, and MAX/MIN value constants, shared with stack_machine. stack_machine's opcode 6 (push variable) lives alongside them.
- One sub-module, fixed_point_divider: sequential restoring divider with start/done. It owns the DIV_ITER counter and contains the only multi-cycle logic.

Test Plan:
- ADD: b=0x0280 (2.5), a=0x0140 (1.25), op=0 -> result 0x03C0, done 2 cycles after start, single pulse.
- SUB order: same operands, op=1 -> 0x0140. Swapped operands -> 0xFEC0 (-1.25).
- MUL: b=0x0280, a=0x0140, op=2 -> 0x0320 (3.125). b=0xFF80 (-0.5), a=0x0300 (3) -> 0xFE80 (-1.5).
- DIV: b=0x0280, a=0x0140, op=3 -> 0x0200 at latency 26. b=0x0100, a=0x0300 -> 0x0055 (truncated 1/3).
- Overflow and divide-by-zero: b=0x7F00 + a=0x7F00 -> 0x7FFF with FIXED_POINT_ALU_SATURATE_EN, 0xFE00 without. DIV b=0xFF00, a=0x0000 -> 0x8000 at latency 2.
- Robustness: start re-asserted mid-DIV is ignored. rst_n low at iteration 10 -> done/result 0 immediately, no done pulse. A subsequent ADD completes normally.
